stopwatch_ctrl: RTL and testbench

Stopwatch sequencer for the 0.01 s time base. It derives a centisecond tick enable from the system clock, without generating a derived clock. It runs a start/stop/lap/clear state machine driven by push-button inputs and maintains a BCD minutes:seconds:centiseconds count. It sits between the synchronised button inputs and the display/segment driver, and replaces the free-running toggled clock as the owner of timing.

---
 rtl/stopwatch_if.sv | 23 ++
 rtl/stopwatch_ctrl.sv | 88 ++++++++
 tb/tb_stopwatch_ctrl.sv | 137 +++++++++++++
 3 files changed

// File: rtl/stopwatch_if.sv
// stopwatch_if: debounced button levels in, BCD display and status out.
interface stopwatch_if;
    logic       btn_start_stop;
    logic       btn_lap;
    logic       btn_clear;
    logic [7:0] disp_min;
    logic [7:0] disp_sec;
    logic [7:0] disp_cs;
    logic [1:0] state;
    logic       running;
    logic       tick;
    logic       wrap;

    modport master (
        output btn_start_stop, btn_lap, btn_clear,
        input  disp_min, disp_sec, disp_cs, state, running, tick, wrap
    );

    modport slave (
        input  btn_start_stop, btn_lap, btn_clear,
        output disp_min, disp_sec, disp_cs, state, running, tick, wrap
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: start/stop/lap/clear sequencer with a centisecond tick enable
// and a BCD mm:ss.cc count; all outputs come straight from flops.
module stopwatch_ctrl #(
    parameter int TICK_DIV = 500000
) (
    input logic        clock_in,
    input logic        rst_n,
    stopwatch_if.slave sw
);
    typedef enum logic [1:0] {IDLE, RUN, LAP, PAUSE} state_t;
    localparam int PW = $clog2(TICK_DIV);

    state_t        st, st_nx;
    logic [2:0]    s1, s2, prev, ev;
    logic [PW-1:0] pre, pre_nx;
    logic [7:0]    cnt_min, cnt_sec, cnt_cs, min_nx, sec_nx, cs_nx;
    logic [7:0]    lap_min, lap_sec, lap_cs, lmin_nx, lsec_nx, lcs_nx;
    logic          active, term, cs_c, sec_c, min_c, clr, load;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] top);
        return v == top ? 8'h00 : v[3:0] == 4'h9 ? {v[7:4] + 4'h1, 4'h0} : v + 8'h01;
    endfunction

    // ev bits: {clear, start_stop, lap}, one cycle per press
    assign ev = s2 & ~prev;
    assign sw.state = st;

    always_comb begin
        active  = st == RUN || st == LAP;
        term    = active && pre == PW'(TICK_DIV - 1);
        cs_c    = cnt_cs == 8'h99;
        sec_c   = cs_c && cnt_sec == 8'h59;
        min_c   = sec_c && cnt_min == 8'h99;
        st_nx   = st == IDLE  ? (ev[1] ? RUN : IDLE) :
                  st == PAUSE ? (ev[2] ? IDLE : ev[1] ? RUN : PAUSE) :
                  ev[1] ? PAUSE : ev[0] ? (st == RUN ? LAP : RUN) : st;
        clr     = st == PAUSE && ev[2];
        load    = st == RUN && st_nx == LAP;
        pre_nx  = clr || term ? '0 : active ? pre + PW'(1) : pre;
        cs_nx   = clr ? 8'h00 : term ? bcd_inc(cnt_cs, 8'h99) : cnt_cs;
        sec_nx  = clr ? 8'h00 : term && cs_c ? bcd_inc(cnt_sec, 8'h59) : cnt_sec;
        min_nx  = clr ? 8'h00 : term && sec_c ? bcd_inc(cnt_min, 8'h99) : cnt_min;
        // snapshot takes the post-edge count, so a tick on the lap edge is included
        lcs_nx  = clr ? 8'h00 : load ? cs_nx : lap_cs;
        lsec_nx = clr ? 8'h00 : load ? sec_nx : lap_sec;
        lmin_nx = clr ? 8'h00 : load ? min_nx : lap_min;
    end

    always_ff @(posedge clock_in or negedge rst_n) begin
        if (!rst_n) begin
            s1          <= '0;
            s2          <= '0;
            prev        <= '0;
            st          <= IDLE;
            pre         <= '0;
            cnt_min     <= '0;
            cnt_sec     <= '0;
            cnt_cs      <= '0;
            lap_min     <= '0;
            lap_sec     <= '0;
            lap_cs      <= '0;
            sw.disp_min <= '0;
            sw.disp_sec <= '0;
            sw.disp_cs  <= '0;
            sw.running  <= 1'b0;
            sw.tick     <= 1'b0;
            sw.wrap     <= 1'b0;
        end else begin
            s1          <= {sw.btn_clear, sw.btn_start_stop, sw.btn_lap};
            s2          <= s1;
            prev        <= s2;
            st          <= st_nx;
            pre         <= pre_nx;
            cnt_min     <= min_nx;
            cnt_sec     <= sec_nx;
            cnt_cs      <= cs_nx;
            lap_min     <= lmin_nx;
            lap_sec     <= lsec_nx;
            lap_cs      <= lcs_nx;
            sw.disp_min <= st_nx == LAP ? lmin_nx : min_nx;
            sw.disp_sec <= st_nx == LAP ? lsec_nx : sec_nx;
            sw.disp_cs  <= st_nx == LAP ? lcs_nx : cs_nx;
            sw.running  <= st_nx == RUN || st_nx == LAP;
            sw.tick     <= term;
            sw.wrap     <= term && min_c;
        end
    end
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed vector table plus hand sequences for wrap and reset.
module tb_stopwatch_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    stopwatch_if sw();

    stopwatch_ctrl #(.TICK_DIV(4)) dut (
        .clock_in(clk),
        .rst_n(rst_n),
        .sw(sw)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       ss, lap, clr;
        int         w;
        logic [1:0] st;
        logic [7:0] mn, sc, cs;
        logic       tk;
    } vec_t;

    vec_t tbl[18];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic check_disp(input string name, input logic [23:0] exp);
        check(name, {8'h00, sw.disp_min, sw.disp_sec, sw.disp_cs}, {8'h00, exp});
    endtask

    initial begin
        int tick_seen;
        // ss lap clr  w    st  min    sec    cs    tick
        tbl[0]  = '{1, 0, 0, 3,   2'd1, 8'h00, 8'h00, 8'h00, 1'b0};
        tbl[1]  = '{0, 0, 0, 400, 2'd1, 8'h00, 8'h01, 8'h00, 1'b1};
        tbl[2]  = '{0, 0, 0, 865, 2'd1, 8'h00, 8'h03, 8'h16, 1'b0};
        tbl[3]  = '{0, 1, 0, 3,   2'd2, 8'h00, 8'h03, 8'h17, 1'b1};
        tbl[4]  = '{0, 0, 0, 200, 2'd2, 8'h00, 8'h03, 8'h17, 1'b1};
        tbl[5]  = '{0, 1, 0, 3,   2'd1, 8'h00, 8'h03, 8'h67, 1'b0};
        tbl[6]  = '{1, 0, 0, 3,   2'd3, 8'h00, 8'h03, 8'h68, 1'b0};
        tbl[7]  = '{0, 0, 0, 100, 2'd3, 8'h00, 8'h03, 8'h68, 1'b0};
        tbl[8]  = '{1, 0, 0, 3,   2'd1, 8'h00, 8'h03, 8'h68, 1'b0};
        tbl[9]  = '{0, 0, 0, 1,   2'd1, 8'h00, 8'h03, 8'h68, 1'b0};
        tbl[10] = '{0, 0, 0, 1,   2'd1, 8'h00, 8'h03, 8'h69, 1'b1};
        tbl[11] = '{1, 0, 0, 3,   2'd3, 8'h00, 8'h03, 8'h69, 1'b0};
        tbl[12] = '{0, 0, 1, 3,   2'd0, 8'h00, 8'h00, 8'h00, 1'b0};
        tbl[13] = '{1, 0, 0, 3,   2'd1, 8'h00, 8'h00, 8'h00, 1'b0};
        tbl[14] = '{1, 0, 0, 3,   2'd3, 8'h00, 8'h00, 8'h00, 1'b0};
        tbl[15] = '{1, 0, 1, 3,   2'd0, 8'h00, 8'h00, 8'h00, 1'b0};
        tbl[16] = '{0, 1, 0, 3,   2'd0, 8'h00, 8'h00, 8'h00, 1'b0};
        tbl[17] = '{0, 0, 1, 3,   2'd0, 8'h00, 8'h00, 8'h00, 1'b0};

        sw.btn_start_stop = 1'b0;
        sw.btn_lap = 1'b0;
        sw.btn_clear = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_state", 32'(sw.state), 32'd0);
        check_disp("rst_disp", 24'h000000);
        check("rst_flags", {29'd0, sw.running, sw.tick, sw.wrap}, 32'd0);
        rst_n = 1'b1;

        tick_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (sw.tick) tick_seen++;
        end
        check("idle_state", 32'(sw.state), 32'd0);
        check_disp("idle_disp", 24'h000000);
        check("idle_ticks", 32'(tick_seen), 32'd0);

        for (int i = 0; i < 18; i++) begin
            sw.btn_start_stop = tbl[i].ss;
            sw.btn_lap = tbl[i].lap;
            sw.btn_clear = tbl[i].clr;
            @(negedge clk);
            sw.btn_start_stop = 1'b0;
            sw.btn_lap = 1'b0;
            sw.btn_clear = 1'b0;
            repeat (tbl[i].w - 1) @(negedge clk);
            check($sformatf("vec%0d_state", i), 32'(sw.state), 32'(tbl[i].st));
            check($sformatf("vec%0d_running", i), 32'(sw.running), 32'(tbl[i].st == 2'd1 || tbl[i].st == 2'd2));
            check_disp($sformatf("vec%0d_disp", i), {tbl[i].mn, tbl[i].sc, tbl[i].cs});
            check($sformatf("vec%0d_tick", i), 32'(sw.tick), 32'(tbl[i].tk));
        end

        // preload 99:59.98 while idle so the rollover is reachable quickly
        force dut.cnt_min = 8'h99;
        force dut.cnt_sec = 8'h59;
        force dut.cnt_cs = 8'h98;
        @(negedge clk);
        release dut.cnt_min;
        release dut.cnt_sec;
        release dut.cnt_cs;
        @(negedge clk);
        check_disp("preload_disp", 24'h995998);
        sw.btn_start_stop = 1'b1;
        @(negedge clk);
        sw.btn_start_stop = 1'b0;
        repeat (2) @(negedge clk);
        check("wrap_run_state", 32'(sw.state), 32'd1);
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            check($sformatf("wrap_tick%0d", i), 32'(sw.tick), 32'(i % 4 == 0));
            check($sformatf("wrap_pulse%0d", i), 32'(sw.wrap), 32'(i == 8));
            if (i == 4) check_disp("wrap_pre_disp", 24'h995999);
            if (i == 8) check_disp("wrap_disp", 24'h000000);
        end
        repeat (4) @(negedge clk);
        check_disp("pre_reset_disp", 24'h000001);

        #2 rst_n = 1'b0;
        sw.btn_start_stop = 1'b1;
        #1;
        check("async_rst_state", 32'(sw.state), 32'd0);
        check_disp("async_rst_disp", 24'h000000);
        check("async_rst_flags", {29'd0, sw.running, sw.tick, sw.wrap}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("held_btn_state", 32'(sw.state), 32'd1);
        repeat (10) @(negedge clk);
        check("held_btn_once", 32'(sw.state), 32'd1);
        sw.btn_start_stop = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
